// File: rtl/muls16_arb.sv
// -----------------------------------------------------------------------------
// muls16_arb : NREQ requesters share one signed 16x16 multiplier through a
// round-robin arbiter and a two-stage pipeline.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : [NREQ]     requester i presents operands
//   req_ready  : [NREQ]     requester i's operands are taken this cycle (one-hot or 0)
//   req_a      : [NREQ*16]  signed operand A, requester i in [16i+15:16i]
//   req_b      : [NREQ*16]  signed operand B, packed like req_a
//   rsp_valid  : a result is presented
//   rsp_ready  : consumer takes the result
//   rsp_id     : [IDW]      requester that owns the result
//   rsp_y      : [32]       signed product
//   busy       : any pipeline stage holds valid data
//   done_cnt   : [16]       completed responses, wrapping
// -----------------------------------------------------------------------------

// Combinational signed 16x16 -> 32 multiplier.
module muls16 (
   input  logic signed [15:0] a,
   input  logic signed [15:0] b,
   output logic signed [31:0] y
);
   logic signed [31:0] a_ext;
   logic signed [31:0] b_ext;

   assign a_ext = 32'(a);
   assign b_ext = 32'(b);
   assign y     = a_ext * b_ext;
endmodule

module muls16_arb #(
   parameter int NREQ = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*16-1:0]      req_a,
   input  logic [NREQ*16-1:0]      req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [31:0]             rsp_y,
   output logic                    busy,
   output logic [15:0]             done_cnt
);
   localparam int IDW    = $clog2(NREQ);
   localparam int DATA_W = 16;

   logic signed [DATA_W-1:0] a_arr [NREQ];
   logic signed [DATA_W-1:0] b_arr [NREQ];

   logic [IDW-1:0]           ptr;
   logic [IDW-1:0]           cand;
   logic [IDW-1:0]           grant_idx;
   logic                     grant_found;
   logic                     accept;
   logic                     s1_adv;
   logic                     s2_adv;
   logic                     rsp_fire;

   logic signed [DATA_W-1:0] a_p1;
   logic signed [DATA_W-1:0] b_p1;
   logic [IDW-1:0]           id_p1;
   logic                     vld_p1;

   logic signed [31:0]       y_p1;

   logic signed [31:0]       y_p2;
   logic [IDW-1:0]           id_p2;
   logic                     vld_p2;

   logic [15:0]              done_q;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign a_arr[g] = $signed(req_a[DATA_W*g +: DATA_W]);
      assign b_arr[g] = $signed(req_b[DATA_W*g +: DATA_W]);
   end

   // Stall chain: S2 frees when empty or drained; S1 frees when empty or moving on.
   assign s2_adv   = !vld_p2 || rsp_ready;
   assign s1_adv   = !vld_p1 || s2_adv;
   assign rsp_fire = vld_p2 && rsp_ready;

   // Round-robin search starting one past the last winner. NREQ is a power
   // of two, so the IDW-bit sum wraps modulo NREQ by itself; k = NREQ lands
   // back on ptr, giving the last winner the lowest priority.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = ptr + IDW'(k);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Only the winner sees ready, and only when S1 can take it. rst_n gates
   // it so nothing looks accepted while the block is held in reset.
   always_comb begin
      req_ready = '0;
      if (rst_n && grant_found && s1_adv) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign accept = |(req_valid & req_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= IDW'(NREQ - 1);
      end else if (accept) begin
         ptr <= grant_idx;
      end
   end

   // ---- S1: granted operands ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         a_p1   <= '0;
         b_p1   <= '0;
         id_p1  <= '0;
      end else if (accept) begin
         vld_p1 <= 1'b1;
         a_p1   <= a_arr[grant_idx];
         b_p1   <= b_arr[grant_idx];
         id_p1  <= grant_idx;
      end else if (s1_adv) begin
         vld_p1 <= 1'b0;
      end
   end

   muls16 u_mul (
      .a (a_p1),
      .b (b_p1),
      .y (y_p1)
   );

   // ---- S2: product and owner ----
   // Data loads only when a real operation moves in, so the presented result
   // stays put under backpressure and between operations.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2 <= 1'b0;
         y_p2   <= '0;
         id_p2  <= '0;
      end else if (s2_adv) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            y_p2  <= y_p1;
            id_p2 <= id_p1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= '0;
      end else if (rsp_fire) begin
         done_q <= done_q + 16'd1;
      end
   end

   assign rsp_valid = vld_p2;
   assign rsp_id    = id_p2;
   assign rsp_y     = y_p2;
   assign busy      = vld_p1 || vld_p2;
   assign done_cnt  = done_q;

endmodule

// File: tb/tb_muls16_arb.sv
// -----------------------------------------------------------------------------
// tb_muls16_arb : directed and randomized bench for muls16_arb (NREQ = 4).
// In-flight work is modelled as an ordered queue of expected (id, product)
// pairs plus occupancy of the two stages; products come from plain integer
// arithmetic on the operands each requester presented when it was granted.
// -----------------------------------------------------------------------------
module tb_muls16_arb;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*16-1:0] req_a = '0;
   logic [NREQ*16-1:0] req_b = '0;
   logic               rsp_valid;
   logic               rsp_ready = 1'b0;
   logic [IDW-1:0]     rsp_id;
   logic [31:0]        rsp_y;
   logic               busy;
   logic [15:0]        done_cnt;

   always #5 clk = ~clk;

   muls16_arb #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .busy      (busy),
      .done_cnt  (done_cnt)
   );

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [31:0]    y;
   } item_t;

   // requesters
   logic [NREQ-1:0]    pend = '0;
   logic               hold_mode = 1'b0;
   logic signed [15:0] op_a [NREQ];
   logic signed [15:0] op_b [NREQ];

   // reference model
   item_t       q[$];
   item_t       rsp_log[$];
   bit          m_s1, m_s2;
   int          m_ptr;
   logic [15:0] m_done;
   int          acc_seen;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] log_y(input int i);
      if (i < rsp_log.size()) return rsp_log[i].y;
      return 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] log_id(input int i);
      if (i < rsp_log.size()) return 32'(rsp_log[i].id);
      return 32'hDEAD_BEEF;
   endfunction

   task automatic drive_inputs();
      req_valid = pend;
      for (int i = 0; i < NREQ; i++) begin
         req_a[16*i +: 16] = op_a[i];
         req_b[16*i +: 16] = op_b[i];
      end
   endtask

   // One clock: drive at the falling edge, check 1 time unit later, step the
   // model at the rising edge, return at the next falling edge.
   task automatic cycle(input logic r);
      int              g, c;
      bit              found, hs, s2_free, s1_free, acc, nxt_s2;
      logic [NREQ-1:0] exp_ready;
      item_t           it;
      rsp_ready = r;
      drive_inputs();
      #1;
      found = 1'b0;
      g     = 0;
      for (int k = 1; k <= NREQ; k++) begin
         c = (m_ptr + k) % NREQ;
         if (!found && pend[c]) begin
            found = 1'b1;
            g     = c;
         end
      end
      hs        = m_s2 && r;
      s2_free   = !m_s2 || r;
      s1_free   = !m_s1 || s2_free;
      acc       = found && s1_free;
      exp_ready = acc ? (NREQ'(1) << g) : '0;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_s2));
      chk("busy",      32'(busy),      32'(m_s1 || m_s2));
      chk("done_cnt",  32'(done_cnt),  32'(m_done));
      if (m_s2) begin
         chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
         chk("rsp_y",  rsp_y,       q[0].y);
      end
      if (rsp_valid && r) begin
         it.id = rsp_id;
         it.y  = rsp_y;
         rsp_log.push_back(it);
      end
      if (|(req_valid & req_ready)) acc_seen++;
      @(posedge clk);
      if (hs) begin
         void'(q.pop_front());
         m_done++;
      end
      nxt_s2 = s2_free ? m_s1 : m_s2;
      m_s1   = acc || (m_s1 && !s2_free);
      m_s2   = nxt_s2;
      if (acc) begin
         it.id = IDW'(g);
         it.y  = 32'(int'(op_a[g]) * int'(op_b[g]));
         q.push_back(it);
         m_ptr = g;
         if (!hold_mode) pend[g] = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic drain();
      for (int n = 0; n < 20 && (m_s1 || m_s2 || pend != '0); n++) cycle(1'b1);
      chk("drain_busy", 32'(busy), 32'd0);
   endtask

   // Asserts reset (asynchronously, mid-cycle), checks outputs while held,
   // then releases on a falling edge.
   task automatic apply_reset();
      drive_inputs();
      rst_n = 1'b0;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_done_cnt",  32'(done_cnt),  32'd0);
      q.delete();
      m_s1   = 1'b0;
      m_s2   = 1'b0;
      m_ptr  = NREQ - 1;
      m_done = '0;
      pend   = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic set_req(input int i, input int a, input int b);
      op_a[i] = 16'(a);
      op_b[i] = 16'(b);
      pend[i] = 1'b1;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end
      pend = '1;
      @(negedge clk);
      apply_reset();

      // single request, first accept right after reset release
      rsp_log.delete();
      set_req(0, -25, 25);
      repeat (4) cycle(1'b1);
      chk("single_n",    32'(rsp_log.size()), 32'd1);
      chk("single_y",    log_y(0),            32'(-625));
      chk("single_id",   log_id(0),           32'd0);
      chk("single_done", 32'(done_cnt),       32'd1);

      // round robin with all requesters held valid
      apply_reset();
      rsp_log.delete();
      set_req(0, -24, 10);
      set_req(1, 32, 32);
      set_req(2, -125, 8);
      set_req(3, 1001, 831);
      hold_mode = 1'b1;
      repeat (5) cycle(1'b1);
      hold_mode = 1'b0;
      pend      = '0;
      drain();
      chk("rr_n",   32'(rsp_log.size()), 32'd5);
      chk("rr_id0", log_id(0), 32'd0);
      chk("rr_id1", log_id(1), 32'd1);
      chk("rr_id2", log_id(2), 32'd2);
      chk("rr_id3", log_id(3), 32'd3);
      chk("rr_id4", log_id(4), 32'd0);
      chk("rr_y0",  log_y(0),  32'(-240));
      chk("rr_y1",  log_y(1),  32'd1024);
      chk("rr_y2",  log_y(2),  32'(-1000));
      chk("rr_y3",  log_y(3),  32'd831831);
      chk("rr_y4",  log_y(4),  32'(-240));

      // backpressure: three requests, consumer stalled five cycles
      rsp_log.delete();
      acc_seen = 0;
      set_req(1, 7, -9);
      set_req(2, 300, -300);
      set_req(3, -1, -1);
      repeat (5) cycle(1'b0);
      chk("bp_accepts", 32'(acc_seen),  32'd2);
      chk("bp_valid",   32'(rsp_valid), 32'd1);
      chk("bp_y",       rsp_y,          32'(-63));
      chk("bp_ready",   32'(req_ready), 32'd0);
      drain();
      chk("bp_n",   32'(rsp_log.size()), 32'd3);
      chk("bp_id0", log_id(0), 32'd1);
      chk("bp_id1", log_id(1), 32'd2);
      chk("bp_id2", log_id(2), 32'd3);
      chk("bp_y1",  log_y(1),  32'(-90000));
      chk("bp_y2",  log_y(2),  32'd1);

      // operand extremes
      rsp_log.delete();
      set_req(0, -32768, -32768);
      set_req(1, -32768, 32767);
      set_req(2, -17, 13);
      drain();
      chk("ext_y0", log_y(0), 32'd1073741824);
      chk("ext_y1", log_y(1), 32'(-1073709056));
      chk("ext_y2", log_y(2), 32'(-221));

      // randomized traffic, including requesters withdrawing before a grant
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               op_a[i] = 16'($urandom);
               op_b[i] = 16'($urandom);
               pend[i] = 1'b1;
            end else if (pend[i] && $urandom_range(0, 15) == 0) begin
               pend[i] = 1'b0;
            end
         end
         cycle($urandom_range(0, 3) != 0);
      end
      pend = '0;
      drain();

      // reset with both stages full
      set_req(0, 100, 200);
      set_req(1, -300, 4);
      repeat (2) cycle(1'b0);
      chk("mid_busy_pre", 32'(busy), 32'd1);
      set_req(3, 5, 5);
      apply_reset();
      rsp_log.delete();
      repeat (5) cycle(1'b1);
      chk("mid_no_stale", 32'(rsp_log.size()), 32'd0);

      // done_cnt wrap: 65535 handshakes at full throughput, then one more
      apply_reset();
      req_valid = 4'b0001;
      rsp_ready = 1'b1;
      req_a     = '0;
      req_b     = '0;
      repeat (65537) @(posedge clk);
      @(negedge clk);
      chk("wrap_pre",  32'(done_cnt), 32'h0000_FFFF);
      @(posedge clk);
      @(negedge clk);
      chk("wrap_zero", 32'(done_cnt), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("wrap_one",  32'(done_cnt), 32'd1);
      req_valid = '0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
